// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RV32I core.
// Opcode constants and the hazard controller state encoding.
package core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT,
        ERROR
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones once reached (W >= 2).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, freezes and flushes for the
// load-use, taken-branch, data-memory wait and post-reset purge cases.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int RESET_FLUSH = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       OPCODE_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic             PCSrc_EX,
    input  logic             MEM_REQ_MEM,
    input  logic             DMEM_READY,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_WRITE,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_WRITE,
    output logic             MEM_WB_BUBBLE,
    output logic             MEM_ERROR,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [3:0]  INIT_LAST = 4'(RESET_FLUSH - 1);
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    hz_state_t   state_q, state_d;
    logic [3:0]  init_q, init_d;
    logic [15:0] wait_q, wait_d;

    logic use_rs1, use_rs2, load_use, mem_stall;
    logic stall_inc, flush_inc;

    assign use_rs1 = (OPCODE_ID != OP_LUI) && (OPCODE_ID != OP_AUIPC) &&
                     (OPCODE_ID != OP_JAL);
    assign use_rs2 = (OPCODE_ID == OP_RTYPE) || (OPCODE_ID == OP_STORE) ||
                     (OPCODE_ID == OP_BRANCH);

    assign load_use = MemRead_EX && (RD_EX != 5'd0) &&
                      ((use_rs1 && (RD_EX == RS1_ID)) ||
                       (use_rs2 && (RD_EX == RS2_ID)));

    assign mem_stall = MEM_REQ_MEM && !DMEM_READY;

    always_comb begin
        PC_WRITE      = 1'b1;
        IF_ID_WRITE   = 1'b1;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_WRITE   = 1'b1;
        ID_EX_FLUSH   = 1'b0;
        EX_MEM_WRITE  = 1'b1;
        MEM_WB_BUBBLE = 1'b0;
        MEM_ERROR     = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        state_d       = state_q;
        init_d        = init_q;
        wait_d        = wait_q;

        unique case (state_q)
            INIT: begin
                PC_WRITE      = 1'b0;
                IF_ID_FLUSH   = 1'b1;
                ID_EX_FLUSH   = 1'b1;
                MEM_WB_BUBBLE = 1'b1;
                init_d        = init_q + 4'd1;
                if (init_q >= INIT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mem_stall) begin
                    PC_WRITE      = 1'b0;
                    IF_ID_WRITE   = 1'b0;
                    ID_EX_WRITE   = 1'b0;
                    EX_MEM_WRITE  = 1'b0;
                    MEM_WB_BUBBLE = 1'b1;
                    stall_inc     = 1'b1;
                    wait_d        = 16'd1;
                    state_d       = MEM_WAIT;
                end else if (PCSrc_EX) begin
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    PC_WRITE    = 1'b0;
                    IF_ID_WRITE = 1'b0;
                    ID_EX_FLUSH = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (DMEM_READY) begin
                    wait_d  = 16'd0;
                    state_d = RUN;
                end else begin
                    PC_WRITE      = 1'b0;
                    IF_ID_WRITE   = 1'b0;
                    ID_EX_WRITE   = 1'b0;
                    EX_MEM_WRITE  = 1'b0;
                    MEM_WB_BUBBLE = 1'b1;
                    stall_inc     = 1'b1;
                    wait_d        = wait_q + 16'd1;
                    if (wait_q >= WAIT_LAST) begin
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                PC_WRITE      = 1'b0;
                IF_ID_WRITE   = 1'b0;
                ID_EX_WRITE   = 1'b0;
                EX_MEM_WRITE  = 1'b0;
                MEM_WB_BUBBLE = 1'b1;
                MEM_ERROR     = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            init_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .q     (STALL_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .q     (FLUSH_CNT)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: default instance plus a short-timeout,
// 2-bit-counter instance driven by the same stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, req, rdy;

    logic        a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_wbb, a_err;
    logic [31:0] a_st, a_fl;
    logic        b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_wbb, b_err;
    logic [1:0]  b_st, b_fl;
    logic [7:0]  a_o, b_o;

    int passed = 0;
    int total  = 0;

    localparam logic [7:0] O_INIT = 8'b0111_1110;
    localparam logic [7:0] O_DEF  = 8'b1101_0100;
    localparam logic [7:0] O_LU   = 8'b0001_1100;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_FRZ  = 8'b0000_0010;
    localparam logic [7:0] O_ERR  = 8'b0000_0011;

    always #5 clk = ~clk;

    hazard_ctrl u_a (
        .clk(clk), .reset(reset),
        .OPCODE_ID(op), .RS1_ID(rs1), .RS2_ID(rs2),
        .MemRead_EX(mr), .RD_EX(rd), .PCSrc_EX(br),
        .MEM_REQ_MEM(req), .DMEM_READY(rdy),
        .PC_WRITE(a_pc), .IF_ID_WRITE(a_ifw), .IF_ID_FLUSH(a_iff),
        .ID_EX_WRITE(a_idw), .ID_EX_FLUSH(a_idf),
        .EX_MEM_WRITE(a_exw), .MEM_WB_BUBBLE(a_wbb),
        .MEM_ERROR(a_err), .STALL_CNT(a_st), .FLUSH_CNT(a_fl)
    );

    hazard_ctrl #(.RESET_FLUSH(2), .MEM_TIMEOUT(4), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset),
        .OPCODE_ID(op), .RS1_ID(rs1), .RS2_ID(rs2),
        .MemRead_EX(mr), .RD_EX(rd), .PCSrc_EX(br),
        .MEM_REQ_MEM(req), .DMEM_READY(rdy),
        .PC_WRITE(b_pc), .IF_ID_WRITE(b_ifw), .IF_ID_FLUSH(b_iff),
        .ID_EX_WRITE(b_idw), .ID_EX_FLUSH(b_idf),
        .EX_MEM_WRITE(b_exw), .MEM_WB_BUBBLE(b_wbb),
        .MEM_ERROR(b_err), .STALL_CNT(b_st), .FLUSH_CNT(b_fl)
    );

    assign a_o = {a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_wbb, a_err};
    assign b_o = {b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_wbb, b_err};

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] o;
        int         st;
        int         fl;
    } vec_t;

    vec_t tv[18];

    function automatic vec_t mk(
        input logic [6:0] op_v, input logic [4:0] r1, input logic [4:0] r2,
        input logic mr_v, input logic [4:0] rd_v, input logic br_v,
        input logic req_v, input logic rdy_v, input logic [7:0] o_v,
        input int st_v, input int fl_v);
        vec_t v;
        v.op = op_v; v.rs1 = r1; v.rs2 = r2; v.mr = mr_v; v.rd = rd_v;
        v.br = br_v; v.req = req_v; v.rdy = rdy_v; v.o = o_v;
        v.st = st_v; v.fl = fl_v;
        return v;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [4:0] r1,
                         input logic [4:0] r2, input logic m,
                         input logic [4:0] d, input logic b,
                         input logic q, input logic y);
        op = o; rs1 = r1; rs2 = r2; mr = m; rd = d;
        br = b; req = q; rdy = y;
    endtask

    task automatic idle();
        drive(7'b0010011, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tv[0]  = mk(7'b0010011, 1, 2, 0, 0, 0, 0, 0, O_INIT, 0, 0);
        tv[1]  = mk(7'b0010011, 1, 2, 0, 0, 0, 0, 0, O_INIT, 0, 0);
        tv[2]  = mk(7'b0010011, 1, 2, 0, 0, 0, 0, 0, O_DEF,  0, 0);
        tv[3]  = mk(7'b0110011, 1, 5, 1, 5, 0, 0, 0, O_LU,   0, 0);
        tv[4]  = mk(7'b0010011, 1, 2, 0, 0, 0, 0, 0, O_DEF,  1, 0);
        tv[5]  = mk(7'b0110011, 1, 5, 1, 0, 0, 0, 0, O_DEF,  1, 0);
        tv[6]  = mk(7'b0110111, 5, 5, 1, 5, 0, 0, 0, O_DEF,  1, 0);
        tv[7]  = mk(7'b0010011, 5, 2, 1, 5, 0, 0, 0, O_LU,   1, 0);
        tv[8]  = mk(7'b0100011, 1, 5, 1, 5, 0, 0, 0, O_LU,   2, 0);
        tv[9]  = mk(7'b0110011, 1, 5, 0, 5, 0, 0, 0, O_DEF,  3, 0);
        tv[10] = mk(7'b0110011, 1, 5, 1, 5, 1, 0, 0, O_BR,   3, 0);
        tv[11] = mk(7'b0010011, 1, 2, 0, 0, 0, 0, 0, O_DEF,  3, 1);
        tv[12] = mk(7'b1101111, 5, 5, 1, 5, 0, 0, 0, O_DEF,  3, 1);
        tv[13] = mk(7'b0110011, 1, 5, 1, 5, 1, 1, 0, O_FRZ,  3, 1);
        tv[14] = mk(7'b0010011, 1, 2, 0, 0, 0, 1, 0, O_FRZ,  4, 1);
        tv[15] = mk(7'b0010011, 1, 2, 0, 0, 0, 1, 0, O_FRZ,  5, 1);
        tv[16] = mk(7'b0010011, 1, 2, 0, 0, 0, 1, 1, O_DEF,  6, 1);
        tv[17] = mk(7'b0010011, 1, 2, 0, 0, 0, 0, 0, O_DEF,  6, 1);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tv[i].op, tv[i].rs1, tv[i].rs2, tv[i].mr, tv[i].rd,
                  tv[i].br, tv[i].req, tv[i].rdy);
            #3;
            chk("a_out", i, 32'(a_o), 32'(tv[i].o));
            chk("a_stall", i, a_st, tv[i].st);
            chk("a_flush", i, a_fl, tv[i].fl);
            chk("b_out", i, 32'(b_o), 32'(tv[i].o));
            chk("b_stall", i, 32'(b_st), sat3(tv[i].st));
            chk("b_flush", i, 32'(b_fl), sat3(tv[i].fl));
            tick();
        end

        // Timeout: instance b errors after 4 wait cycles, a keeps waiting.
        do_reset();
        #3;
        chk("rst_a_out", 0, 32'(a_o), 32'(O_INIT));
        chk("rst_a_stall", 0, a_st, 0);
        chk("rst_a_flush", 0, a_fl, 0);
        chk("rst_b_stall", 0, 32'(b_st), 0);
        tick();
        tick();
        drive(7'b0010011, 1, 2, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            #3;
            chk("to_b_frz", i, 32'(b_o), 32'(O_FRZ));
            tick();
        end
        #3;
        chk("to_b_err", 5, 32'(b_o), 32'(O_ERR));
        chk("to_a_frz", 5, 32'(a_o), 32'(O_FRZ));
        tick();
        rdy = 1'b1;
        #3;
        chk("to_b_sticky", 6, 32'(b_o), 32'(O_ERR));
        chk("to_a_def", 6, 32'(a_o), 32'(O_DEF));
        chk("to_a_stall", 6, a_st, 5);
        chk("to_b_stall", 6, 32'(b_st), 3);
        chk("to_b_flush", 6, 32'(b_fl), 0);
        tick();
        idle();
        #3;
        chk("to_b_held", 7, 32'(b_o), 32'(O_ERR));
        tick();

        // Reset clears the error, then a reset in the middle of a wait.
        do_reset();
        #3;
        chk("clr_b_out", 0, 32'(b_o), 32'(O_INIT));
        chk("clr_b_stall", 0, 32'(b_st), 0);
        tick();
        tick();
        drive(7'b0010011, 1, 2, 0, 0, 0, 1, 0);
        tick();
        tick();
        tick();
        do_reset();
        #3;
        chk("mid_a_out", 0, 32'(a_o), 32'(O_INIT));
        chk("mid_b_out", 0, 32'(b_o), 32'(O_INIT));
        chk("mid_a_stall", 0, a_st, 0);
        tick();
        #3;
        chk("mid_a_init2", 1, 32'(a_o), 32'(O_INIT));
        tick();
        drive(7'b0010011, 1, 2, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            #3;
            chk("mid_b_frz", i, 32'(b_o), 32'(O_FRZ));
            tick();
        end
        rdy = 1'b1;
        #3;
        chk("mid_b_def", 4, 32'(b_o), 32'(O_DEF));
        chk("mid_a_stall", 4, a_st, 3);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
